posit_decode_pipe: RTL
======================

# posit_decode_pipe

Pipelined, streaming posit decoder with a valid/ready handshake, parametrised in N and ES (ES = 0 supported). It accepts one posit word per cycle and produces unpacked fields: sign, special flags, regime value k, exponent, combined scale and a hidden-bit-normalised significand. It sits between the posit operand registers and the PPU arithmetic cores, replacing the purely combinational decoder on timing-critical paths.

## Interface
- N, 16: posit width in bits, N ≥ 5.
- ES, 1: exponent field width, 0 ≤ ES ≤ 4.
- S, $clog2(N): width of regime-run counters.
- CW, 16: width of statistics counters (used only with the configuration macro).
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts a word this cycle.
- in_bits  in  N  posit word.
- out_valid  out  1  decoded result present.
- out_ready  in  1  downstream accepts a result this cycle.
- out_sign  out  1  posit sign bit.
- out_is_zero  out  1  input was all zeros.
- out_is_nar  out  1  input was 1 followed by N-1 zeros.
- out_k  out  S+1  signed regime value.
- out_exp  out  max(ES,1)  exponent field; constant 0 when ES = 0.
- out_scale  out  S+ES+2  signed, k·2^ES + exp.
- out_frac  out  N  significand, hidden 1 at bit N-1, fraction bits below, zero-padded at LSBs.
- cnt_zero, cnt_nar, cnt_total  out  CW each  statistics counters (present only with macro).

## Operation
- Stage 1 (on accept): register sign, flags, magnitude u = sign ? two's-complement(in_bits) : in_bits, regime bit r = u[N-2], run length m = leading copies of r in u[N-2:0].
- Stage 2: k = r ? m-1 : -m; reg_len = min(m+1, N-1); exponent = next ES bits after regime, missing bits (truncated by regime) read as 0; fraction = remaining N-1-reg_len-ES bits (0 if negative), left-aligned below the hidden bit.
- Zero or NaR: out_k, out_exp, out_scale, out_frac all 0; out_sign = in_bits[N-1].
- Negative values decode magnitude; out_sign carries the sign only.
- Each stage holds a valid bit; stage i advances when it is empty or stage i+1 is accepting (ready_i = !valid_i || ready_{i+1}); in_ready = ready_1; final stage ready = out_ready.
- Output data is stable while out_valid && !out_ready.

## Timing
- Latency: 2 cycles from accept (in_valid && in_ready at edge t) to out_valid at edge t+2, absent backpressure.
- Throughput: 1 word/cycle with out_ready held high.
- Full pipeline with out_ready low: in_ready drops combinationally the same cycle; no word is lost or duplicated.
- Simultaneous accept and drain in a full pipeline: both happen; occupancy unchanged.
- Reset: all valid bits 0, in_ready = 1 after reset, every data output 0, counters 0. Reset mid-stream discards all in-flight words; no output appears from them.
- in_ready is a function of state and out_ready only, never of in_valid.

## Configuration
- POSIT_DECODE_STATS_EN defined: cnt_zero, cnt_nar, cnt_total exist; each increments by 1 when a result is delivered (out_valid && out_ready) with the matching class (cnt_total for every result); saturate at 2^CW-1; cleared only by rst.
- Undefined: counter ports and logic absent; decode behaviour identical.

## Test plan
- N=8 ES=0, stream 0x40, 0x50, 0x60, 0x7F, 0x01 with out_ready=1 -> scale 0/0/1/6/-6, frac 0x80/0xC0/0x80/0x80/0x80, one result per cycle, 2-cycle latency.
- N=8 ES=0, 0xC0, 0x00, 0x80 -> sign 1 scale 0 frac 0x80; is_zero=1; is_nar=1 with all fields 0.
- N=16 ES=1, 0x4000, 0x5000, 0x0001 -> scale 0/1/-28, exp 0/1/0, frac 0x8000.
- Backpressure: random in_valid and out_ready over 1000 words vs golden model -> identical ordered output stream, no drops or duplicates, outputs stable while stalled.
- Assert rst for one cycle with both stages full -> out_valid=0 next cycle, in_ready=1, no stale results afterwards.
- With POSIT_DECODE_STATS_EN, CW=4: deliver 20 zeros -> cnt_zero=15 saturated, cnt_total=15, cnt_nar=0.

Source files
------------

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage streaming posit decoder with valid/ready flow control.
// Stage 1 registers the sign, the zero/NaR flags, the magnitude body and the regime run
// length. Stage 2 turns those into k, exponent, scale and a hidden-bit-normalised
// significand, and holds the result until it is taken downstream.
// Optional build macro POSIT_DECODE_STATS_EN adds saturating delivery counters
// (cnt_zero, cnt_nar, cnt_total) of width CW.
module posit_decode_pipe #(
    parameter int N  = 16,
    parameter int ES = 1,
    parameter int S  = $clog2(N),
    parameter int CW = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  in_bits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign,
    output logic                          out_is_zero,
    output logic                          out_is_nar,
    output logic signed [S:0]             out_k,
    output logic [((ES > 0) ? ES : 1)-1:0] out_exp,
    output logic signed [S+ES+1:0]        out_scale,
    output logic [N-1:0]                  out_frac
`ifdef POSIT_DECODE_STATS_EN
    ,
    output logic [CW-1:0]                 cnt_zero,
    output logic [CW-1:0]                 cnt_nar,
    output logic [CW-1:0]                 cnt_total
`endif
);

    localparam int EW  = (ES > 0) ? ES : 1;
    localparam int SCW = S + ES + 2;
    localparam logic [S:0] LMAX = (S+1)'(N - 1);

    if (N < 5) begin : g_bad_n
        $error("posit_decode_pipe: N must be at least 5");
    end
    if (ES < 0 || ES > 4) begin : g_bad_es
        $error("posit_decode_pipe: ES must be in 0..4");
    end
    if (CW < 1) begin : g_bad_cw
        $error("posit_decode_pipe: CW must be positive");
    end

    // ---------------------------------------------------------------- stage 1
    logic               r_s1_valid;
    logic               r_s1_sign;
    logic               r_s1_zero;
    logic               r_s1_nar;
    logic               r_s1_r;
    logic [N-2:0]       r_s1_body;
    logic [S-1:0]       r_s1_m;

    // ---------------------------------------------------------------- stage 2
    logic               r_s2_valid;
    logic               r_out_sign;
    logic               r_out_zero;
    logic               r_out_nar;
    logic signed [S:0]  r_out_k;
    logic [EW-1:0]      r_out_exp;
    logic signed [SCW-1:0] r_out_scale;
    logic [N-1:0]       r_out_frac;

    logic               w_ready1;
    logic               w_ready2;
    logic               w_sign;
    logic               w_zero;
    logic               w_nar;
    logic [N-2:0]       w_body;
    logic               w_r;
    logic [S-1:0]       w_m;
    logic               w_run;

    logic [S:0]         w_m_ext;
    logic [S:0]         w_mp1;
    logic [S:0]         w_reg_len;
    logic signed [S:0]  w_k;
    logic [N-2:0]       w_rest;
    logic [N-2:0]       w_frac_bits;
    logic [EW-1:0]      w_exp;
    logic signed [SCW-1:0] w_k_ext;
    logic signed [SCW-1:0] w_scale;
    logic               w_special;

    // Pipeline flow control: a stage may load when empty or when its successor drains it.
    assign w_ready2 = !r_s2_valid || out_ready;
    assign w_ready1 = !r_s1_valid || w_ready2;
    assign in_ready = w_ready1;

    // Input classification and magnitude. Only the N-1 bits below the sign are kept;
    // the low bits of a two's complement equal the two's complement of the low bits.
    assign w_sign = in_bits[N-1];
    assign w_zero = (in_bits == '0);
    assign w_nar  = (in_bits == {1'b1, {(N-1){1'b0}}});
    assign w_body = w_sign ? (~in_bits[N-2:0] + (N-1)'(1)) : in_bits[N-2:0];
    assign w_r    = w_body[N-2];

    // Regime run length: count leading copies of the regime bit, stop at the first change.
    always_comb begin
        w_m   = '0;
        w_run = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (w_run && (w_body[i] == w_r)) begin
                w_m = w_m + S'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Stage-1 register: capture the classified word whenever the stage is allowed to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_r     <= 1'b0;
            r_s1_body  <= '0;
            r_s1_m     <= '0;
        end else if (w_ready1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_sign;
                r_s1_zero <= w_zero;
                r_s1_nar  <= w_nar;
                r_s1_r    <= w_r;
                r_s1_body <= w_body;
                r_s1_m    <= w_m;
            end
        end
    end

    // Regime value and length; the regime never consumes more than the N-1 body bits.
    always_comb begin
        w_m_ext   = {1'b0, r_s1_m};
        w_mp1     = w_m_ext + (S+1)'(1);
        w_reg_len = (w_mp1 > LMAX) ? LMAX : w_mp1;
        w_k       = r_s1_r ? $signed(w_m_ext - (S+1)'(1)) : -$signed(w_m_ext);
    end

    // Shifting the regime out leaves exponent then fraction at the top; bits pushed past
    // the end of the word come back as zeros, which is exactly the truncation rule.
    assign w_rest      = r_s1_body << w_reg_len;
    assign w_frac_bits = w_rest << ES;

    if (ES > 0) begin : g_exp
        assign w_exp = w_rest[N-2 -: EW];
    end else begin : g_noexp
        assign w_exp = '0;
    end

    // Combined scale k*2^ES + exp, computed in a width that cannot overflow.
    always_comb begin
        w_k_ext = SCW'(w_k);
        w_scale = (w_k_ext <<< ES) + $signed(SCW'(w_exp));
    end

    assign w_special = r_s1_zero || r_s1_nar;

    // Stage-2 register: the output holding register, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_nar   <= 1'b0;
            r_out_k     <= '0;
            r_out_exp   <= '0;
            r_out_scale <= '0;
            r_out_frac  <= '0;
        end else if (w_ready2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sign <= r_s1_sign;
                r_out_zero <= r_s1_zero;
                r_out_nar  <= r_s1_nar;
                if (w_special) begin
                    r_out_k     <= '0;
                    r_out_exp   <= '0;
                    r_out_scale <= '0;
                    r_out_frac  <= '0;
                end else begin
                    r_out_k     <= w_k;
                    r_out_exp   <= w_exp;
                    r_out_scale <= w_scale;
                    r_out_frac  <= {1'b1, w_frac_bits};
                end
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_sign    = r_out_sign;
    assign out_is_zero = r_out_zero;
    assign out_is_nar  = r_out_nar;
    assign out_k       = r_out_k;
    assign out_exp     = r_out_exp;
    assign out_scale   = r_out_scale;
    assign out_frac    = r_out_frac;

`ifdef POSIT_DECODE_STATS_EN
    logic [CW-1:0] r_cnt_zero;
    logic [CW-1:0] r_cnt_nar;
    logic [CW-1:0] r_cnt_total;
    logic          w_deliver;

    assign w_deliver = r_s2_valid && out_ready;

    // Saturating counters of delivered results, by class.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_zero  <= '0;
            r_cnt_nar   <= '0;
            r_cnt_total <= '0;
        end else if (w_deliver) begin
            if (r_cnt_total != '1) begin
                r_cnt_total <= r_cnt_total + CW'(1);
            end
            if (r_out_zero && (r_cnt_zero != '1)) begin
                r_cnt_zero <= r_cnt_zero + CW'(1);
            end
            if (r_out_nar && (r_cnt_nar != '1)) begin
                r_cnt_nar <= r_cnt_nar + CW'(1);
            end
        end
    end

    assign cnt_zero  = r_cnt_zero;
    assign cnt_nar   = r_cnt_nar;
    assign cnt_total = r_cnt_total;
`endif

endmodule
